// File: rtl/aac_pcm_write_feeder.sv
// PCM write feeder: packs 16-bit sample pairs into 32-bit words, buffers them and hands
// one address/data request at a time to the AXI write master, waiting for each response.
module aac_pcm_write_feeder #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned REGION_WORDS = 512
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [15:0] pcm_sample,
  input  logic        pcm_valid,
  input  logic        pcm_last,
  output logic        pcm_ready,
  output logic [31:0] aacaddr,
  output logic [31:0] aacdata,
  output logic        aacaddrvalid,
  output logic        aacdatavalid,
  input  logic        wr_done,
  input  logic [1:0]  wr_resp,
  output logic        frame_done,
  output logic [7:0]  err_count
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0] CNT_ONE   = (PW+1)'(1);
  localparam logic [PW:0] CNT_ZERO  = (PW+1)'(0);
  localparam logic [PW:0] CNT_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (REGION_WORDS - 1));

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // FIFO entry: {last flag, packed word}
  logic [32:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic [15:0]   hold_r;
  logic          half_r;
  logic [1:0]    state_r;
  logic [31:0]   addr_r;

  logic          pcm_ready_r;
  logic [31:0]   aacaddr_r;
  logic [31:0]   aacdata_r;
  logic          addrvalid_r;
  logic          datavalid_r;
  logic          frame_done_r;
  logic [7:0]    err_count_r;

  logic          accept_s;
  logic          push_s;
  logic [32:0]   push_word_s;
  logic          pop_s;
  logic [PW:0]   count_nxt_s;
  logic [32:0]   head_s;

  assign accept_s = pcm_valid & pcm_ready_r;
  assign pop_s    = (state_r == ST_WAIT) & wr_done;
  assign head_s   = fifo_mem_r[rd_ptr_r];

  // Word completion: a second sample, or a lone sample flagged last, produces a push.
  always_comb begin
    push_s      = 1'b0;
    push_word_s = 33'd0;
    if (accept_s && half_r) begin
      push_s      = 1'b1;
      push_word_s = {pcm_last, pcm_sample, hold_r};
    end else if (accept_s && pcm_last) begin
      push_s      = 1'b1;
      push_word_s = {1'b1, 16'h0000, pcm_sample};
    end else begin
      push_s      = 1'b0;
      push_word_s = 33'd0;
    end
  end

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge aclk) begin
    if (push_s && !areset) begin
      fifo_mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  // Input packing, FIFO pointers and the registered ready flag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      hold_r      <= 16'h0000;
      half_r      <= 1'b0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= CNT_ZERO;
      pcm_ready_r <= 1'b1;
    end else begin
      if (accept_s) begin
        if (half_r || pcm_last) begin
          half_r <= 1'b0;
        end else begin
          hold_r <= pcm_sample;
          half_r <= 1'b1;
        end
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_nxt_s;
      pcm_ready_r <= (count_nxt_s < CNT_FULL);
    end
  end

  // Request FSM: issue one word, hold it until the write response, then advance.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r      <= ST_IDLE;
      addr_r       <= BASE_ADDR;
      aacaddr_r    <= 32'd0;
      aacdata_r    <= 32'd0;
      addrvalid_r  <= 1'b0;
      datavalid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      err_count_r  <= 8'd0;
    end else begin
      addrvalid_r  <= 1'b0;
      datavalid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (count_r != CNT_ZERO) begin
            state_r     <= ST_ISSUE;
            aacaddr_r   <= addr_r;
            aacdata_r   <= head_s[31:0];
            addrvalid_r <= 1'b1;
            datavalid_r <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wr_done) begin
            state_r      <= ST_IDLE;
            frame_done_r <= head_s[32];
            // Failed writes are not retried; the address moves on regardless.
            addr_r       <= (addr_r == LAST_ADDR) ? BASE_ADDR : addr_r + 32'd4;
            if ((wr_resp != 2'b00) && (err_count_r != 8'hFF)) begin
              err_count_r <= err_count_r + 8'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign pcm_ready    = pcm_ready_r;
  assign aacaddr      = aacaddr_r;
  assign aacdata      = aacdata_r;
  assign aacaddrvalid = addrvalid_r;
  assign aacdatavalid = datavalid_r;
  assign frame_done   = frame_done_r;
  assign err_count    = err_count_r;

endmodule
